sram64_req_adapter: RTL and testbench

Request-side adapter that presents the 128x32 dual-port SRAM macro as a 64-entry x 64-bit single-port memory with valid/ready handshakes. It splits each 64-bit access into a low-word access on macro port A (rows 0–63) and a high-word access on macro port B (rows 64–127). It expands byte enables to bit masks and re-times the macro's one-cycle read data. A 2-entry response buffer lets the consumer back-pressure without losing read data. It sits between the cache/scratchpad request logic and the macro instance.

---
 rtl/sram64_pkg.sv | 27 ++
 rtl/sram64_rsp_fifo.sv | 60 ++++++
 rtl/sram64_req_adapter.sv | 149 ++++++++++++++
 tb/tb_sram64_req_adapter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram64_pkg.sv
// Shared types and constants for the 64x64 single-port view of the 128x32 dual-port SRAM macro.
package sram64_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 64;
  localparam int BE_W   = 8;
  localparam int HALF_W = 32;

  localparam logic [3:0] RM_DEFAULT = 4'b0010;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } sram64_req_t;

  // Expand four byte enables into a 32-bit per-bit write mask for one macro port.
  function automatic logic [HALF_W-1:0] be_to_mask(input logic [BE_W/2-1:0] be);
    logic [HALF_W-1:0] mask;
    for (int i = 0; i < HALF_W; i++) begin
      mask[i] = be[i/8];
    end
    return mask;
  endfunction

endpackage

// File: rtl/sram64_rsp_fifo.sv
// Small response FIFO with wrap-around pointers and an occupancy count.
module sram64_rsp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array; data is not reset, only the control state below is.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram64_req_adapter.sv
// Presents the 128x32 dual-port macro as a 64x64 single-port memory with valid/ready
// handshakes. Low word lives on port A rows 0-63, high word on port B rows 64-127.
module sram64_req_adapter
  import sram64_pkg::*;
#(
  parameter int         RSP_DEPTH = 2,
  parameter logic [3:0] RM_VAL    = RM_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [BE_W-1:0]   req_be_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              mea_o,
  output logic              meb_o,
  output logic              wea_o,
  output logic              web_o,
  output logic [6:0]        adra_o,
  output logic [6:0]        adrb_o,
  output logic [HALF_W-1:0] da_o,
  output logic [HALF_W-1:0] db_o,
  output logic [HALF_W-1:0] wema_o,
  output logic [HALF_W-1:0] wemb_o,
  input  logic [HALF_W-1:0] qa_i,
  input  logic [HALF_W-1:0] qb_i,
  output logic              test1_o,
  output logic              rme_o,
  output logic              ls_o,
  output logic [3:0]        rm_o
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  sram64_req_t       req;
  logic              accept;
  logic              lo_act;
  logic              hi_act;
  logic              rd_inflight;
  logic [CNT_W:0]    occupancy;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic [DATA_W-1:0] bypass_data;
  logic              push;
  logic              pop;

  assign req = '{we: req_we_i, addr: req_addr_i, wdata: req_wdata_i, be: req_be_i};

  assign test1_o = 1'b0;
  assign rme_o   = 1'b0;
  assign ls_o    = 1'b0;
  assign rm_o    = RM_VAL;

  // Credit check: a request (read or write) is only taken while a response slot is free.
  always_comb begin
    occupancy   = {1'b0, fifo_cnt} + {{CNT_W{1'b0}}, rd_inflight};
    req_ready_o = !rst_i && (occupancy < (CNT_W + 1)'(RSP_DEPTH));
  end

  assign accept = req_valid_i && req_ready_o;

  // A read uses both halves; a write only enables the halves with at least one byte set.
  assign lo_act = !req.we || (|req.be[BE_W/2-1:0]);
  assign hi_act = !req.we || (|req.be[BE_W-1:BE_W/2]);

  // Macro pins are driven straight from the request in the accept cycle, idle otherwise.
  always_comb begin
    mea_o  = 1'b0;
    meb_o  = 1'b0;
    wea_o  = 1'b0;
    web_o  = 1'b0;
    adra_o = '0;
    adrb_o = '0;
    da_o   = '0;
    db_o   = '0;
    wema_o = '0;
    wemb_o = '0;
    if (accept && (lo_act || hi_act)) begin
      mea_o  = lo_act;
      meb_o  = hi_act;
      wea_o  = req.we && lo_act;
      web_o  = req.we && hi_act;
      adra_o = {1'b0, req.addr};
      adrb_o = {1'b1, req.addr};
      da_o   = req.wdata[HALF_W-1:0];
      db_o   = req.wdata[DATA_W-1:HALF_W];
      wema_o = be_to_mask(req.be[BE_W/2-1:0]);
      wemb_o = be_to_mask(req.be[BE_W-1:BE_W/2]);
    end
  end

  // Accept stage -> macro read stage: remember that macro data arrives next cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_inflight <= 1'b0;
    end else begin
      rd_inflight <= accept && !req.we;
    end
  end

  assign bypass_data = {qb_i, qa_i};

  // Buffered data has priority; fresh macro data bypasses only when nothing is queued.
  always_comb begin
    rsp_valid_o = 1'b0;
    rsp_rdata_o = '0;
    if (!rst_i) begin
      if (!fifo_empty) begin
        rsp_valid_o = 1'b1;
        rsp_rdata_o = fifo_dout;
      end else if (rd_inflight) begin
        rsp_valid_o = 1'b1;
        rsp_rdata_o = bypass_data;
      end
    end
  end

  // Macro data is captured whenever it cannot leave through the bypass this cycle.
  always_comb begin
    push = !rst_i && rd_inflight && (!fifo_empty || !rsp_ready_i);
    pop  = !rst_i && !fifo_empty && rsp_ready_i;
  end

  sram64_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_W)
  ) u_rsp_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .pop   (pop),
    .din   (bypass_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) !(push && fifo_full))
    else $error("response buffer push while full");

endmodule

// File: tb/tb_sram64_req_adapter.sv
// Scoreboard bench: a 64x64 reference memory predicts read data, a 128x32 macro model
// sits on the pin side, and monitors compare handshakes, pins and responses.
module tb_sram64_req_adapter;

  localparam int         RSP_DEPTH = 2;
  localparam logic [3:0] RM_VAL    = 4'b0010;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [5:0]  req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_be;
  logic        rsp_valid, rsp_ready;
  logic [63:0] rsp_rdata;
  logic        mea, meb, wea, web;
  logic [6:0]  adra, adrb;
  logic [31:0] da, db, wema, wemb, qa, qb;
  logic        test1, rme, ls;
  logic [3:0]  rm;

  sram64_req_adapter #(.RSP_DEPTH(RSP_DEPTH), .RM_VAL(RM_VAL)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .mea_o(mea), .meb_o(meb), .wea_o(wea), .web_o(web),
    .adra_o(adra), .adrb_o(adrb), .da_o(da), .db_o(db),
    .wema_o(wema), .wemb_o(wemb), .qa_i(qa), .qb_i(qb),
    .test1_o(test1), .rme_o(rme), .ls_o(ls), .rm_o(rm)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] macro_mem [128];
  logic [63:0] ref_mem   [64];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural 128x32 dual-port macro with one-cycle read latency and bit masks.
  always @(posedge clk) begin
    if (mea) begin
      if (wea) macro_mem[adra] = (macro_mem[adra] & ~wema) | (da & wema);
      else     qa <= macro_mem[adra];
    end
    if (meb) begin
      if (web) macro_mem[adrb] = (macro_mem[adrb] & ~wemb) | (db & wemb);
      else     qb <= macro_mem[adrb];
    end
  end

  // Request-side monitor: credit rule, pin mapping, and reference-memory update.
  always @(negedge clk) begin
    logic         exp_ready, acc, lo, hi;
    logic [159:0] exp_pins, act_pins;
    logic [31:0]  ma, mb;
    exp_ready = !rst && (exp_q.size() < RSP_DEPTH);
    check("req_ready", {159'd0, req_ready}, {159'd0, exp_ready});
    check("const_pins", {153'd0, test1, rme, ls, rm}, {153'd0, 3'b000, RM_VAL});
    if (rst) exp_q.delete();
    acc = req_valid && req_ready;
    lo  = !req_we || (req_be[3:0] != 4'h0);
    hi  = !req_we || (req_be[7:4] != 4'h0);
    for (int k = 0; k < 4; k++) begin
      ma[8*k +: 8] = {8{req_be[k]}};
      mb[8*k +: 8] = {8{req_be[k+4]}};
    end
    exp_pins = '0;
    if (acc && (lo || hi))
      exp_pins = {lo, hi, req_we && lo, req_we && hi, 1'b0, req_addr, 1'b1, req_addr,
                  req_wdata[31:0], req_wdata[63:32], ma, mb};
    act_pins = {mea, meb, wea, web, adra, adrb, da, db, wema, wemb};
    check("macro_pins", act_pins, exp_pins);
    if (acc) begin
      if (req_we) begin
        for (int k = 0; k < 8; k++)
          if (req_be[k]) ref_mem[req_addr][8*k +: 8] = req_wdata[8*k +: 8];
      end else begin
        exp_q.push_back('{data: ref_mem[req_addr], cyc: cyc});
      end
    end
  end

  // Response-side monitor: presence, ordering, data and stability of read responses.
  always @(negedge clk) begin
    logic exp_v;
    #1;
    if (rst) begin
      check("rsp_valid_rst", {159'd0, rsp_valid}, 160'd0);
      check("rsp_rdata_rst", {96'd0, rsp_rdata}, 160'd0);
    end else begin
      exp_v = (exp_q.size() > 0) && (exp_q[0].cyc < cyc);
      check("rsp_valid", {159'd0, rsp_valid}, {159'd0, exp_v});
      if (rsp_valid && exp_v) begin
        check("rsp_rdata", {96'd0, rsp_rdata}, {96'd0, exp_q[0].data});
        if (rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic issue(input logic we, input logic [5:0] a, input logic [63:0] d,
                       input logic [7:0] be);
    int waited = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
    @(negedge clk);
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL req_accept_timeout: ready=%0b required 1 within 50 cycles", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  logic rand_done;

  initial begin
    logic [31:0] lo_w, hi_w;
    for (int a = 0; a < 64; a++) begin
      lo_w = $urandom; hi_w = $urandom;
      macro_mem[a] = lo_w; macro_mem[a+64] = hi_w;
      ref_mem[a] = {hi_w, lo_w};
    end
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_be = '0; rsp_ready = 1'b1; rand_done = 1'b0;
    idle(3);
    rst = 1'b0;

    // Full write then read-back of the same word.
    issue(1'b1, 6'd5, 64'h0123_4567_89AB_CDEF, 8'hFF);
    issue(1'b0, 6'd5, 64'(0), 8'h00);
    idle(2);
    // Low-half partial write.
    issue(1'b1, 6'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    issue(1'b0, 6'd5, 64'(0), 8'hFF);
    idle(2);
    // Row boundaries.
    issue(1'b1, 6'd0, 64'hA5A5_0000_5A5A_1111, 8'hFF);
    issue(1'b1, 6'd63, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF);
    issue(1'b0, 6'd0, 64'(0), 8'h00);
    issue(1'b0, 6'd63, 64'(0), 8'h00);
    idle(2);
    // Write with no byte enables leaves memory alone.
    issue(1'b1, 6'd63, 64'h1111_2222_3333_4444, 8'h00);
    issue(1'b0, 6'd63, 64'(0), 8'h00);
    idle(2);

    // Back-pressure: third read waits until the consumer drains.
    rsp_ready = 1'b0;
    fork
      begin
        issue(1'b0, 6'd5, 64'(0), 8'h00);
        issue(1'b0, 6'd0, 64'(0), 8'h00);
        issue(1'b0, 6'd63, 64'(0), 8'h00);
      end
      begin
        idle(6);
        rsp_ready = 1'b1;
      end
    join
    idle(3);

    // Reset with one response buffered and one read in flight.
    rsp_ready = 1'b0;
    issue(1'b0, 6'd1, 64'(0), 8'h00);
    issue(1'b0, 6'd2, 64'(0), 8'h00);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(1);
    rsp_ready = 1'b1;
    idle(2);

    // Randomized traffic with random consumer back-pressure.
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(0, 3) != 0) begin
            logic [7:0] be;
            case ($urandom_range(0, 7))
              0:       be = 8'h00;
              1:       be = 8'hFF;
              default: be = 8'($urandom);
            endcase
            issue(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 7)) : 6'($urandom),
                  {$urandom, $urandom}, be);
          end else begin
            idle(1);
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          rsp_ready = 1'($urandom_range(0, 1));
        end
      end
    join

    rsp_ready = 1'b1;
    for (int w = 0; w < 100 && exp_q.size() > 0; w++) idle(1);
    check("drain_empty", 160'(exp_q.size()), 160'd0);
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
